countdown_timer_core: RTL

//  MM:SS kitchen-timer countdown engine; the stage directly upstream of the 4-digit display multiplexer.

---
 rtl/countdown_timer_pkg.sv | 80 ++++++++
 rtl/countdown_timer_core_bcd_to_seg7.sv | 27 ++
 rtl/countdown_timer_core.sv | 124 ++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types, state encoding and 7-segment table for the MM:SS countdown timer.
// BCD time arithmetic helpers live here so the top stays a plain FSM.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Borrow ripples seconds-ones -> seconds-tens -> minutes; saturates at 00:00.
    function automatic bcd_time_t time_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t != '0) begin
            if (t.so != 4'd0) begin
                r.so = t.so - 4'd1;
            end else begin
                r.so = 4'd9;
                if (t.st != 4'd0) begin
                    r.st = t.st - 4'd1;
                end else begin
                    r.st = 4'd5;
                    if (t.mo != 4'd0) begin
                        r.mo = t.mo - 4'd1;
                    end else begin
                        r.mo = 4'd9;
                        r.mt = t.mt - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t sec_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.so == 4'd9) begin
            r.so = 4'd0;
            r.st = (t.st == 4'd5) ? 4'd0 : t.st + 4'd1;
        end else begin
            r.so = t.so + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t min_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.mo == 4'd9) begin
            r.mo = 4'd0;
            r.mt = (t.mt == 4'd9) ? 4'd0 : t.mt + 4'd1;
        end else begin
            r.mo = t.mo + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_core_bcd_to_seg7.sv
// Combinational BCD digit to active-low {a,b,c,d,e,f,g} segment code.
// Non-BCD codes blank the digit.
module bcd_to_seg7
    import countdown_timer_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS countdown engine: FSM, 1 Hz and blink prescalers, BCD time register
// and registered active-low segment outputs for the display multiplexer.
module countdown_timer_core
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       clr,
    output logic [6:0] c1,
    output logic [6:0] c2,
    output logic [6:0] c3,
    output logic [6:0] c4,
    output logic       running,
    output logic       alarm
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_e          state_q, state_d;
    bcd_time_t       time_q, time_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            phase_q, phase_d;
    logic [6:0]      c1_q, c2_q, c3_q, c4_q;
    logic            running_q, alarm_q;
    logic [6:0]      seg_so, seg_st, seg_mo, seg_mt;
    logic            tick, is_zero, is_one, blank;

    assign tick    = (state_q == ST_RUN) && (tcnt_q == TICK_LAST);
    assign is_zero = (time_q == '0);
    assign is_one  = (time_q == bcd_time_t'(16'h0001));
    assign blank   = (state_q == ST_ALARM) && phase_q;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (clr) begin
            state_d = ST_IDLE;
            time_d  = '0;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE, ST_PAUSE: if (!is_zero) state_d = ST_RUN;
                ST_RUN:            state_d = ST_PAUSE;
                ST_ALARM:          state_d = ST_IDLE;
                default:           state_d = ST_IDLE;
            endcase
        end else if (tick) begin
            time_d = time_dec(time_q);
            if (is_one) state_d = ST_ALARM;
        end else if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
            if (inc_sec) time_d = sec_inc(time_d);
            if (inc_min) time_d = min_inc(time_d);
        end
    end

    // Both prescalers restart from zero whenever their state is (re)entered.
    always_comb begin
        tcnt_d  = '0;
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        end
        if (state_q == ST_ALARM && state_d == ST_ALARM) begin
            phase_d = phase_q;
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    bcd_to_seg7 u_so (.bcd_i(time_q.so), .seg_o(seg_so));
    bcd_to_seg7 u_st (.bcd_i(time_q.st), .seg_o(seg_st));
    bcd_to_seg7 u_mo (.bcd_i(time_q.mo), .seg_o(seg_mo));
    bcd_to_seg7 u_mt (.bcd_i(time_q.mt), .seg_o(seg_mt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            c1_q      <= SEG_0;
            c2_q      <= SEG_0;
            c3_q      <= SEG_0;
            c4_q      <= SEG_0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            c1_q      <= blank ? SEG_BLANK : seg_so;
            c2_q      <= blank ? SEG_BLANK : seg_st;
            c3_q      <= blank ? SEG_BLANK : seg_mo;
            c4_q      <= blank ? SEG_BLANK : seg_mt;
            running_q <= (state_q == ST_RUN);
            alarm_q   <= (state_q == ST_ALARM);
        end
    end

    assign c1      = c1_q;
    assign c2      = c2_q;
    assign c3      = c3_q;
    assign c4      = c4_q;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule
